// File: rtl/multicycle_mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between the core
// (requester 0) and a DMA/loader port (requester 1); one transaction in flight.
module multicycle_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_W-1:0]     c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  input  logic [DATA_W/8-1:0]   c_be,
  output logic                  c_ack,
  output logic [DATA_W-1:0]     c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  bus_err,
  output logic                  owner
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant;
  logic [CNT_W-1:0]    cnt_q, cnt_inc;
  logic                grant, gnt_dma, done_ok, done_to;
  logic [DATA_W-1:0]   resp_data;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    gnt_dma   = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          grant   = 1'b1;
          gnt_dma = d_req && (!c_req || !last_grant);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (m_ack) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (TO_EN && (cnt_inc == CNT_LIM)) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_data = (done_ok && !m_we) ? m_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt_q      <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (grant) begin
        m_req      <= 1'b1;
        m_we       <= gnt_dma ? d_we    : c_we;
        m_addr     <= gnt_dma ? d_addr  : c_addr;
        m_wdata    <= gnt_dma ? d_wdata : c_wdata;
        m_be       <= gnt_dma ? d_be    : c_be;
        owner      <= gnt_dma;
        last_grant <= gnt_dma;
        cnt_q      <= '0;
      end
      // Completion (ack or timeout) registers the response shown during RESP.
      if (done_ok || done_to) begin
        m_req   <= 1'b0;
        bus_err <= done_to;
        c_ack   <= !owner;
        d_ack   <= owner;
        if (owner) d_rdata <= resp_data;
        else       c_rdata <= resp_data;
      end else if (TO_EN && (state_q == BUSY)) begin
        cnt_q <= cnt_inc;
      end
    end
  end

endmodule
